// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, idle line level and the
// bit-period helper. The future uart_tx imports this package too.
`timescale 1ns/1ps
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } uart_rx_state_t;

  // The line rests high between frames. A start bit is the first low level.
  localparam logic UART_IDLE_LVL = 1'b1;

  // Returns the number of gclk cycles per serial bit. The division truncates.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sync.sv
// bit_sync: two-flop synchroniser that brings one asynchronous bit into the
// gclk domain.
//   gclk  : destination clock
//   rst_n : asynchronous active-low reset; both flops are loaded with RESET_VAL
//   d     : asynchronous input
//   q     : synchronised output, delayed by two gclk cycles
`timescale 1ns/1ps
module bit_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic gclk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: the flops use non-blocking assignments, so meta and q both take the
  // value they had before the edge. With blocking assignments the two stages
  // would merge into one.
  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling receiver for 8N1-style serial frames, with DATA_BITS
// data bits, sent LSB first.
//   gclk       : system clock
//   rst_n      : asynchronous active-low reset
//   uart_rx_in : raw serial line; idles high; asynchronous to gclk
//   rx_data    : received byte; stable while rx_valid is high
//   rx_valid   : the holding register is full
//   rx_ready   : the consumer accepts; a transfer is rx_valid & rx_ready
//   frame_err  : 1-cycle pulse when the stop bit is sampled low
//   overrun    : 1-cycle pulse when a completed byte is dropped because the
//                holding register is full
//   busy       : high whenever the FSM is not idle
`timescale 1ns/1ps
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8
) (
  input  logic                 gclk,
  input  logic                 rst_n,
  input  logic                 uart_rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CPB   = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W = $clog2(CPB);
  localparam int IDX_W = $clog2(DATA_BITS);

  // The first reload aims at the middle of the start bit. Every reload after
  // that moves on by one full bit period, so each sample stays near a bit centre.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CPB - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_BITS - 1);

  logic                 rxs;
  logic [CNT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     idx;
  logic [DATA_BITS-1:0] shift_reg;
  uart_rx_state_t       state;
  logic                 tick;

  bit_sync #(.RESET_VAL(UART_IDLE_LVL)) u_sync (
    .gclk  (gclk),
    .rst_n (rst_n),
    .d     (uart_rx_in),
    .q     (rxs)
  );

  assign tick = (bit_cnt == '0);

  always_ff @(posedge gclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      idx       <= '0;
      shift_reg <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;

      // A transfer empties the holding register. A delivery in the STOP
      // branch further down can refill it in the same cycle.
      if (rx_valid && rx_ready) rx_valid <= 1'b0;

      if (!tick) bit_cnt <= bit_cnt - 1'b1;

      unique case (state)
        IDLE: begin
          if (rxs != UART_IDLE_LVL) begin
            state   <= START;
            bit_cnt <= HALF_LOAD;
            busy    <= 1'b1;
          end
        end

        START: begin
          if (tick) begin
            if (rxs == 1'b0) begin
              state   <= DATA;
              bit_cnt <= FULL_LOAD;
              idx     <= '0;
            end else begin
              // The line is already high again, so the low level was a glitch.
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        DATA: begin
          if (tick) begin
            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
            bit_cnt   <= FULL_LOAD;
            if (idx == LAST_IDX) state <= STOP;
            else                 idx   <= idx + 1'b1;
          end
        end

        STOP: begin
          if (tick) begin
            if (rxs == 1'b1) begin
              if (!rx_valid || rx_ready) begin
                rx_data  <= shift_reg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= WAIT_HIGH;
            end
          end
        end

        WAIT_HIGH: begin
          // A break holds the line low. Wait for the high level so the break
          // is not read as a string of 0x00 frames.
          if (rxs == 1'b1) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB = 16;

  logic       gclk = 1'b0;
  logic       rst_n;
  logic       uart_rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  uart_rx #(
    .CLK_HZ    (1_600_000),
    .BAUD      (100_000),
    .DATA_BITS (8)
  ) dut (
    .gclk       (gclk),
    .rst_n      (rst_n),
    .uart_rx_in (uart_rx_in),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 gclk = ~gclk;

  // The monitor counts events on the falling edge, away from the active edge.
  int         cyc = 0;
  int         fe_cnt = 0, ov_cnt = 0, both_cnt = 0, wide_cnt = 0;
  int         vhi_cnt = 0, xfer_cnt = 0, t_rise = 0;
  logic [7:0] last_xfer = '0;
  logic       fe_prev = 1'b0, ov_prev = 1'b0, rv_prev = 1'b0;
  int         t_fall = 0;

  always @(posedge gclk) cyc <= cyc + 1;

  always @(negedge gclk) begin
    if (frame_err) fe_cnt <= fe_cnt + 1;
    if (overrun) ov_cnt <= ov_cnt + 1;
    if (frame_err && overrun) both_cnt <= both_cnt + 1;
    if ((frame_err && fe_prev) || (overrun && ov_prev)) wide_cnt <= wide_cnt + 1;
    fe_prev <= frame_err;
    ov_prev <= overrun;
    if (rx_valid && !rv_prev) t_rise <= cyc;
    rv_prev <= rx_valid;
    if (rx_valid) vhi_cnt <= vhi_cnt + 1;
    if (rx_valid && rx_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= rx_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One full frame: start bit, 8 data bits sent LSB first, then the stop bit.
  // The task returns at the end of the stop bit and leaves the line at the
  // stop level.
  task automatic send_frame(input logic [7:0] d, input logic stop);
    @(posedge gclk); #1;
    t_fall = cyc;
    uart_rx_in = 1'b0;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(posedge gclk);
      #1 uart_rx_in = d[i];
    end
    repeat (CPB) @(posedge gclk);
    #1 uart_rx_in = stop;
    repeat (CPB) @(posedge gclk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge gclk);
    #1;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_xfer;
    logic [7:0] exp_data;
    int         exp_fe;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int fe0, ov0, xf0, vh0;

    vecs[0] = '{data: 8'h00, stop: 1'b1, exp_xfer: 1, exp_data: 8'h00, exp_fe: 0};
    vecs[1] = '{data: 8'hFF, stop: 1'b1, exp_xfer: 1, exp_data: 8'hFF, exp_fe: 0};
    vecs[2] = '{data: 8'h5A, stop: 1'b1, exp_xfer: 1, exp_data: 8'h5A, exp_fe: 0};
    vecs[3] = '{data: 8'h81, stop: 1'b1, exp_xfer: 1, exp_data: 8'h81, exp_fe: 0};
    vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_xfer: 0, exp_data: 8'h00, exp_fe: 1};
    vecs[5] = '{data: 8'h96, stop: 1'b1, exp_xfer: 1, exp_data: 8'h96, exp_fe: 0};

    rst_n      = 1'b0;
    uart_rx_in = 1'b1;
    rx_ready   = 1'b0;
    idle(4);
    check("reset rx_data", 32'(rx_data), 32'h0);
    check("reset rx_valid", 32'(rx_valid), 32'h0);
    check("reset frame_err", 32'(frame_err), 32'h0);
    check("reset overrun", 32'(overrun), 32'h0);
    check("reset busy", 32'(busy), 32'h0);
    @(negedge gclk) rst_n = 1'b1;
    idle(8);
    check("idle busy", 32'(busy), 32'h0);

    // 0xA3 with rx_ready high. rx_valid rises 153 cycles after the
    // synchronised line falls, plus 2 cycles for the synchroniser, so 155
    // cycles after the pin falls. rx_valid stays high for one cycle only.
    rx_ready = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt; xf0 = xfer_cnt; vh0 = vhi_cnt;
    send_frame(8'hA3, 1'b1);
    idle(2 * CPB);
    check("A3 latency", 32'(t_rise - t_fall), 32'd155);
    check("A3 data", 32'(last_xfer), 32'hA3);
    check("A3 xfer count", 32'(xfer_cnt - xf0), 32'd1);
    check("A3 valid width", 32'(vhi_cnt - vh0), 32'd1);
    check("A3 no frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("A3 no overrun", 32'(ov_cnt - ov0), 32'd0);

    // The vector table, sent with rx_ready high.
    for (int v = 0; v < 6; v++) begin
      fe0 = fe_cnt; xf0 = xfer_cnt;
      send_frame(vecs[v].data, vecs[v].stop);
      uart_rx_in = 1'b1;
      idle(2 * CPB);
      check($sformatf("vec%0d xfer", v), 32'(xfer_cnt - xf0), 32'(vecs[v].exp_xfer));
      check($sformatf("vec%0d frame_err", v), 32'(fe_cnt - fe0), 32'(vecs[v].exp_fe));
      if (vecs[v].exp_xfer != 0)
        check($sformatf("vec%0d data", v), 32'(last_xfer), 32'(vecs[v].exp_data));
    end

    // Overrun: 0x12 then 0x34 back to back, with nothing accepting them.
    rx_ready = 1'b0;
    fe0 = fe_cnt; ov0 = ov_cnt; xf0 = xfer_cnt;
    send_frame(8'h12, 1'b1);
    send_frame(8'h34, 1'b1);
    idle(CPB);
    check("ovr count", 32'(ov_cnt - ov0), 32'd1);
    check("ovr no frame_err", 32'(fe_cnt - fe0), 32'd0);
    check("ovr rx_valid", 32'(rx_valid), 32'h1);
    check("ovr rx_data kept", 32'(rx_data), 32'h12);
    rx_ready = 1'b1;
    idle(1);
    check("ovr drained valid", 32'(rx_valid), 32'h0);
    check("ovr drained data", 32'(last_xfer), 32'h12);
    check("ovr one xfer", 32'(xfer_cnt - xf0), 32'd1);

    // A 5-cycle glitch on the idle line.
    fe0 = fe_cnt; xf0 = xfer_cnt;
    @(posedge gclk); #1 uart_rx_in = 1'b0;
    idle(5);
    uart_rx_in = 1'b1;
    check("glitch busy high", 32'(busy), 32'h1);
    idle(9);
    check("glitch busy cleared", 32'(busy), 32'h0);
    idle(2 * CPB);
    check("glitch no xfer", 32'(xfer_cnt - xf0), 32'd0);
    check("glitch no frame_err", 32'(fe_cnt - fe0), 32'd0);

    // Break: the line is held low for 40 bit times. Expect exactly one
    // frame_err pulse, and busy stays high until the line returns high.
    fe0 = fe_cnt; xf0 = xfer_cnt;
    @(posedge gclk); #1 uart_rx_in = 1'b0;
    idle(40 * CPB);
    check("break frame_err once", 32'(fe_cnt - fe0), 32'd1);
    check("break busy held", 32'(busy), 32'h1);
    check("break no xfer", 32'(xfer_cnt - xf0), 32'd0);
    uart_rx_in = 1'b1;
    idle(4);
    check("break busy released", 32'(busy), 32'h0);
    send_frame(8'h55, 1'b1);
    idle(2 * CPB);
    check("post-break data", 32'(last_xfer), 32'h55);
    check("post-break xfer", 32'(xfer_cnt - xf0), 32'd1);

    // 0x55 is held. rx_ready rises exactly in the cycle that loads 0xAA.
    rx_ready = 1'b0;
    send_frame(8'h55, 1'b1);
    idle(CPB);
    ov0 = ov_cnt; xf0 = xfer_cnt;
    fork
      send_frame(8'hAA, 1'b1);
      begin
        @(posedge gclk);
        repeat (154) @(posedge gclk);
        #1 rx_ready = 1'b1;
        @(posedge gclk);
        #1 rx_ready = 1'b0;
        check("simul rx_valid", 32'(rx_valid), 32'h1);
        check("simul rx_data", 32'(rx_data), 32'hAA);
      end
    join
    idle(CPB);
    check("simul xfer 55", 32'(last_xfer), 32'h55);
    check("simul one xfer", 32'(xfer_cnt - xf0), 32'd1);
    check("simul no overrun", 32'(ov_cnt - ov0), 32'd0);
    rx_ready = 1'b1;
    idle(2);
    check("simul drain AA", 32'(last_xfer), 32'hAA);

    // Reset in the middle of the DATA bits of 0xC3.
    xf0 = xfer_cnt;
    fork
      send_frame(8'hC3, 1'b1);
      begin
        @(posedge gclk);
        repeat (60) @(posedge gclk);
        #3 rst_n = 1'b0;
        #1;
        check("midrst rx_data", 32'(rx_data), 32'h0);
        check("midrst rx_valid", 32'(rx_valid), 32'h0);
        check("midrst busy", 32'(busy), 32'h0);
        check("midrst pulses", 32'({frame_err, overrun}), 32'h0);
      end
    join
    @(negedge gclk) rst_n = 1'b1;
    idle(20);
    send_frame(8'h7E, 1'b1);
    idle(2 * CPB);
    check("post-reset data", 32'(last_xfer), 32'h7E);
    check("post-reset xfer", 32'(xfer_cnt - xf0), 32'd1);

    check("pulses never together", 32'(both_cnt), 32'd0);
    check("pulses single cycle", 32'(wide_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
